// File: rtl/irq_ctrl_if.sv
// Data-bus port bundle for irq_ctrl.
// Master drives the access; slave returns registered read data.
interface irq_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data_w;
  logic              wr_en;
  logic [31:0]       data_r;

  modport master (
    output addr, data_w, wr_en,
    input  data_r
  );

  modport slave (
    input  addr, data_w, wr_en,
    output data_r
  );
endinterface

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt flag controller with claim/complete encoder.
// Define IRQ_CTRL_SYNC_EN to add a 2-flop synchroniser on src.
module irq_ctrl #(
  parameter int NSRC   = 32,
  parameter int ADDR_W = 32
) (
  input  logic            clock,
  input  logic            reset,
  irq_ctrl_if.slave       bus,
  input  logic [NSRC-1:0] src,
  output logic            interrupt
);

  logic [NSRC-1:0] ien_q;
  logic [NSRC-1:0] if_q;
  logic [NSRC-1:0] edge_q;
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] src_s;
  logic [NSRC-1:0] hw_set;
  logic [NSRC-1:0] sw_set;
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] pend;
  logic [31:0]     claim_id;
  logic [31:0]     rd;
  logic            off_ien;
  logic            off_if;
  logic            off_ifc;
  logic            off_ifs;
  logic            off_edge;
  logic            off_claim;

`ifdef IRQ_CTRL_SYNC_EN
  logic [NSRC-1:0] sync1;
  logic [NSRC-1:0] sync2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= src;
      sync2 <= sync1;
    end
  end

  assign src_s = sync2;
`else
  assign src_s = src;
`endif

  assign off_ien   = bus.addr == ADDR_W'(0);
  assign off_if    = bus.addr == ADDR_W'(1);
  assign off_ifc   = bus.addr == ADDR_W'(2);
  assign off_ifs   = bus.addr == ADDR_W'(3);
  assign off_edge  = bus.addr == ADDR_W'(4);
  assign off_claim = bus.addr == ADDR_W'(5);

  assign hw_set = (edge_q & src_s & ~src_q)
                | (~edge_q & src_s);
  assign sw_set = (bus.wr_en && off_ifs)
                ? bus.data_w[NSRC-1:0] : '0;
  assign pend   = if_q & ien_q;

  always_comb begin
    clr = '0;
    if (bus.wr_en && off_ifc)
      clr = bus.data_w[NSRC-1:0];
    for (int i = 0; i < NSRC; i++) begin
      if (bus.wr_en && off_claim
          && bus.data_w == 32'(i + 1))
        clr[i] = 1'b1;
    end
  end

  // Scan downward so the lowest pending index wins.
  always_comb begin
    claim_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (pend[i])
        claim_id = 32'(i + 1);
    end
  end

  always_comb begin
    rd = '0;
    unique case (1'b1)
      off_ien:   rd = 32'(ien_q);
      off_if:    rd = 32'(if_q);
      off_edge:  rd = 32'(edge_q);
      off_claim: rd = claim_id;
      default:   rd = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ien_q      <= '0;
      if_q       <= '0;
      edge_q     <= '0;
      src_q      <= '0;
      bus.data_r <= '0;
      interrupt  <= 1'b0;
    end else begin
      src_q      <= src_s;
      if_q       <= (if_q & ~clr) | hw_set | sw_set;
      bus.data_r <= rd;
      interrupt  <= |pend;
      if (bus.wr_en && off_ien)
        ien_q <= bus.data_w[NSRC-1:0];
      if (bus.wr_en && off_edge)
        edge_q <= bus.data_w[NSRC-1:0];
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl.
// Inputs change and outputs are sampled on the falling edge.
module tb_irq_ctrl;

  localparam int NSRC = 32;

  logic            clock;
  logic            reset;
  logic [NSRC-1:0] src;
  logic            interrupt;
  logic [31:0]     val;
  int              n_chk;
  int              n_fail;

  irq_ctrl_if #(.ADDR_W(32)) bus ();

  irq_ctrl #(
    .NSRC   (NSRC),
    .ADDR_W (32)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .src       (src),
    .interrupt (interrupt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic wr(
    input logic [31:0] a,
    input logic [31:0] d
  );
    bus.addr   = a;
    bus.data_w = d;
    bus.wr_en  = 1'b1;
    @(negedge clock);
    bus.wr_en  = 1'b0;
    bus.data_w = '0;
  endtask

  task automatic rd(
    input  logic [31:0] a,
    output logic [31:0] d
  );
    bus.addr  = a;
    bus.wr_en = 1'b0;
    @(negedge clock);
    d = bus.data_r;
  endtask

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    reset      = 1'b1;
    src        = '0;
    bus.addr   = '0;
    bus.data_w = '0;
    bus.wr_en  = 1'b0;
    #1;
    check("rst_irq", 32'(interrupt), 32'd0);
    check("rst_data", bus.data_r, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // register access basics
    wr(0, 32'h0000_00A5);
    rd(0, val);
    check("ien_rb", val, 32'h0000_00A5);
    wr(4, 32'h0000_1200);
    rd(4, val);
    check("edge_rb", val, 32'h0000_1200);
    wr(1, 32'hFFFF_FFFF);
    rd(1, val);
    check("if_ro", val, 32'd0);
    wr(3, 32'h0000_0100);
    rd(3, val);
    check("ifs_rd0", val, 32'd0);
    rd(2, val);
    check("ifc_rd0", val, 32'd0);
    rd(6, val);
    check("off6_rd0", val, 32'd0);
    rd(1, val);
    check("ifs_set", val, 32'h0000_0100);
    wr(5, 32'd33);
    wr(5, 32'd0);
    rd(1, val);
    check("claim_oor", val, 32'h0000_0100);
    wr(2, 32'hFFFF_FFFF);
    wr(4, 32'd0);

    // level source cannot be cleared while high
    wr(0, 32'h1);
    src = 32'h1;
    wr(2, 32'h1);
    rd(1, val);
    check("lvl_hold", val, 32'h1);
    check("lvl_irq", 32'(interrupt), 32'd1);
    src = '0;
    wr(2, 32'h1);
    check("lvl_irq_n1", 32'(interrupt), 32'd1);
    @(negedge clock);
    check("lvl_irq_n2", 32'(interrupt), 32'd0);

    // edge mode captures once per rising edge
    wr(4, 32'h2);
    wr(0, 32'h2);
    src = 32'h2;
    repeat (5) @(negedge clock);
    rd(1, val);
    check("edg_set", val, 32'h2);
    wr(5, 32'd2);
    rd(1, val);
    check("edg_claim", val, 32'd0);
    rd(1, val);
    check("edg_norearm", val, 32'd0);
    src = '0;
    @(negedge clock);
    src = 32'h2;
    @(negedge clock);
    rd(1, val);
    check("edg_rearm", val, 32'h2);
    src = '0;
    wr(2, 32'hFFFF_FFFF);
    wr(4, 32'd0);

    // lowest index wins the claim
    wr(0, 32'hFF);
    wr(3, 32'h28);
    rd(5, val);
    check("pri_4", val, 32'd4);
    wr(5, 32'd4);
    rd(5, val);
    check("pri_6", val, 32'd6);
    wr(5, 32'd6);
    rd(5, val);
    check("pri_0", val, 32'd0);
    check("pri_irq", 32'(interrupt), 32'd0);

    // capture is unmasked
    wr(0, 32'd0);
    src = 32'h4;
    @(negedge clock);
    src = '0;
    rd(1, val);
    check("msk_if", val, 32'h4);
    check("msk_irq", 32'(interrupt), 32'd0);
    wr(0, 32'h4);
    check("msk_irq_n1", 32'(interrupt), 32'd0);
    @(negedge clock);
    check("msk_irq_n2", 32'(interrupt), 32'd1);
    wr(0, 32'd0);
    wr(2, 32'hFFFF_FFFF);

    // set beats clear in the same cycle
    wr(4, 32'h8);
    src = 32'h8;
    wr(2, 32'h8);
    rd(1, val);
    check("col_if", val, 32'h8);
    wr(3, 32'h10);
    rd(1, val);
    check("col_ifs", val, 32'h18);
    wr(2, 32'h10);
    rd(1, val);
    check("col_ifc", val, 32'h8);
    src = '0;

    // asynchronous reset mid-run
    wr(4, 32'd0);
    wr(2, 32'hFFFF_FFFF);
    wr(0, 32'hF);
    wr(3, 32'hF);
    rd(1, val);
    check("pre_if", val, 32'hF);
    check("pre_irq", 32'(interrupt), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_irq", 32'(interrupt), 32'd0);
    check("mid_data", bus.data_r, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int a = 0; a < 7; a++) begin
      rd(32'(a), val);
      check($sformatf("post_rd%0d", a), val, 32'd0);
    end
    check("post_irq", 32'(interrupt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
